dual_ram_asym: RTL and testbench

Single-clock true dual-port RAM with asymmetric port widths: port A accesses DWA-bit words, port B accesses MULTNUM×DWA-bit words over the same storage. It has per-lane write enables on port B, a selectable read-during-write mode and an optional output register. A built-in clear sequence zeroes the array after reset. It generalises the team's basic dual_ram for datapaths that pack several narrow samples into one wide bus word inside one clock domain.

---
 rtl/dual_ram_asym.sv | 168 ++++++++++++++++
 tb/tb_dual_ram_asym.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_asym.sv
// Single-clock true dual-port RAM: port A sees DWA-bit words, port B sees MULTNUM packed
// lanes of the same storage. A clear sequence zeroes the array after every reset.
module dual_ram_asym #(
    parameter  int DWA     = 16,
    parameter  int AWA     = 6,
    parameter  int MULTNUM = 4,
    parameter  int RD_MODE = 0,
    parameter  int OUT_REG = 0,
    localparam int LGM     = $clog2(MULTNUM),
    localparam int DWB     = MULTNUM * DWA,
    localparam int AWB     = AWA - LGM
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_ready,
    input  logic               i_en_a,
    input  logic               i_wr_en_a,
    input  logic [AWA-1:0]     i_addr_a,
    input  logic [DWA-1:0]     i_data_a,
    output logic [DWA-1:0]     o_data_a,
    output logic               o_valid_a,
    input  logic               i_en_b,
    input  logic               i_wr_en_b,
    input  logic [MULTNUM-1:0] i_be_b,
    input  logic [AWB-1:0]     i_addr_b,
    input  logic [DWB-1:0]     i_data_b,
    output logic [DWB-1:0]     o_data_b,
    output logic               o_valid_b,
    output logic               o_collision
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e         state_q, state_d;
    logic [AWA-1:0] clr_cnt_q, clr_cnt_d;
    logic           clearing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clearing  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearing  = 1'b1;
                clr_cnt_d = clr_cnt_q + AWA'(1);
                if (clr_cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    logic run, acc_a, wr_a, acc_b, wr_b;
    assign run   = (state_q == ST_RUN);
    assign acc_a = run & i_en_a;
    assign wr_a  = acc_a & i_wr_en_a;
    assign acc_b = run & i_en_b;
    assign wr_b  = acc_b & i_wr_en_b;

    logic [DWA-1:0] mem [2**AWA];
    logic [AWA-1:0] lane_addr [MULTNUM];

    // Lane j of B word k is A word {k, j}; lane 0 at the LSBs.
    always_comb begin
        for (int j = 0; j < MULTNUM; j++) begin
            lane_addr[j] = AWA'(AWA'(i_addr_b) << LGM) | AWA'(j);
        end
    end

    // Port B writes come last so they win on a colliding word.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr_a) mem[i_addr_a] <= i_data_a;
            for (int j = 0; j < MULTNUM; j++) begin
                if (wr_b && i_be_b[j]) mem[lane_addr[j]] <= i_data_b[j*DWA +: DWA];
            end
        end
    end

    logic [DWA-1:0] rd_a;
    logic [DWB-1:0] rd_b;
    logic           coll;

    // Cross-port reads always see pre-edge contents; only own-port writes forward.
    always_comb begin
        rd_a = mem[i_addr_a];
        if (RD_MODE == 1 && wr_a) rd_a = i_data_a;
        rd_b = '0;
        coll = 1'b0;
        for (int j = 0; j < MULTNUM; j++) begin
            rd_b[j*DWA +: DWA] = mem[lane_addr[j]];
            if (RD_MODE == 1 && wr_b && i_be_b[j]) rd_b[j*DWA +: DWA] = i_data_b[j*DWA +: DWA];
            if (wr_a && wr_b && i_be_b[j] && (lane_addr[j] == i_addr_a)) coll = 1'b1;
        end
    end

    logic [DWA-1:0] data_a_q, data_a_d;
    logic [DWB-1:0] data_b_q, data_b_d;
    logic           valid_a_q, valid_b_q, coll_q;

    assign data_a_d = acc_a ? rd_a : data_a_q;
    assign data_b_d = acc_b ? rd_b : data_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= acc_a;
            valid_b_q <= acc_b;
            coll_q    <= coll;
        end
    end

    assign o_ready = run;

    if (OUT_REG != 0) begin : g_oreg
        logic [DWA-1:0] data_a_r;
        logic [DWB-1:0] data_b_r;
        logic           valid_a_r, valid_b_r, coll_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_a_r  <= '0;
                data_b_r  <= '0;
                valid_a_r <= 1'b0;
                valid_b_r <= 1'b0;
                coll_r    <= 1'b0;
            end else begin
                data_a_r  <= data_a_q;
                data_b_r  <= data_b_q;
                valid_a_r <= valid_a_q;
                valid_b_r <= valid_b_q;
                coll_r    <= coll_q;
            end
        end

        assign o_data_a    = data_a_r;
        assign o_data_b    = data_b_r;
        assign o_valid_a   = valid_a_r;
        assign o_valid_b   = valid_b_r;
        assign o_collision = coll_r;
    end else begin : g_noreg
        assign o_data_a    = data_a_q;
        assign o_data_b    = data_b_q;
        assign o_valid_a   = valid_a_q;
        assign o_valid_b   = valid_b_q;
        assign o_collision = coll_q;
    end

endmodule

// File: tb/tb_dual_ram_asym.sv
// Directed bench: two instances share stimulus, one read-first without output register,
// one write-first with output register, so both modes and latencies are checked together.
module tb_dual_ram_asym;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [5:0]  addr_a = '0;
    logic [15:0] wdata_a = '0;
    logic [3:0]  be_b = '0;
    logic [3:0]  addr_b = '0;
    logic [63:0] wdata_b = '0;

    logic        ready0, ready1, valid_a0, valid_a1, valid_b0, valid_b1, coll0, coll1;
    logic [15:0] data_a0, data_a1;
    logic [63:0] data_b0, data_b1;

    int n_vec = 0;
    int n_err = 0;
    int coll_cnt0 = 0;
    int coll_cnt1 = 0;

    always #5 clk = ~clk;

    dual_ram_asym #(.DWA(16), .AWA(6), .MULTNUM(4), .RD_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .o_ready(ready0),
        .i_en_a(en_a), .i_wr_en_a(we_a), .i_addr_a(addr_a), .i_data_a(wdata_a),
        .o_data_a(data_a0), .o_valid_a(valid_a0),
        .i_en_b(en_b), .i_wr_en_b(we_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_data_b(wdata_b),
        .o_data_b(data_b0), .o_valid_b(valid_b0), .o_collision(coll0)
    );

    dual_ram_asym #(.DWA(16), .AWA(6), .MULTNUM(4), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .o_ready(ready1),
        .i_en_a(en_a), .i_wr_en_a(we_a), .i_addr_a(addr_a), .i_data_a(wdata_a),
        .o_data_a(data_a1), .o_valid_a(valid_a1),
        .i_en_b(en_b), .i_wr_en_b(we_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_data_b(wdata_b),
        .o_data_b(data_b1), .o_valid_b(valid_b1), .o_collision(coll1)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            coll_cnt0 = coll_cnt0 + int'(coll0);
            coll_cnt1 = coll_cnt1 + int'(coll1);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; be_b = '0;
    endtask

    // Called at a negedge; dut0 results appear one edge later, dut1 results two edges later.
    task automatic do_op(input string tag,
                         input logic en_a_i, input logic we_a_i, input logic [5:0] addr_a_i,
                         input logic [15:0] data_a_i,
                         input logic en_b_i, input logic we_b_i, input logic [3:0] be_i,
                         input logic [3:0] addr_b_i, input logic [63:0] data_b_i,
                         input logic [15:0] exp_a0, input logic [15:0] exp_a1,
                         input logic [63:0] exp_b0, input logic [63:0] exp_b1,
                         input logic exp_coll);
        en_a = en_a_i; we_a = we_a_i; addr_a = addr_a_i; wdata_a = data_a_i;
        en_b = en_b_i; we_b = we_b_i; be_b = be_i; addr_b = addr_b_i; wdata_b = data_b_i;
        @(negedge clk);
        idle_inputs();
        check_eq({tag, "_va0"}, 64'(valid_a0), 64'(en_a_i));
        check_eq({tag, "_vb0"}, 64'(valid_b0), 64'(en_b_i));
        check_eq({tag, "_va1_early"}, 64'(valid_a1), 64'd0);
        check_eq({tag, "_col0"}, 64'(coll0), 64'(exp_coll));
        check_eq({tag, "_col1_early"}, 64'(coll1), 64'd0);
        if (en_a_i) check_eq({tag, "_a0"}, 64'(data_a0), 64'(exp_a0));
        if (en_b_i) check_eq({tag, "_b0"}, data_b0, exp_b0);
        @(negedge clk);
        check_eq({tag, "_va1"}, 64'(valid_a1), 64'(en_a_i));
        check_eq({tag, "_vb1"}, 64'(valid_b1), 64'(en_b_i));
        check_eq({tag, "_va0_pulse"}, 64'(valid_a0), 64'd0);
        check_eq({tag, "_col1"}, 64'(coll1), 64'(exp_coll));
        if (en_a_i && !exp_coll) check_eq({tag, "_a1"}, 64'(data_a1), 64'(exp_a1));
        if (en_a_i) check_eq({tag, "_a0_hold"}, 64'(data_a0), 64'(exp_a0));
        if (en_b_i) check_eq({tag, "_b1"}, data_b1, exp_b1);
    endtask

    task automatic wait_ready(input string tag, input int exp_edges);
        int n = 0;
        while (!(ready0 && ready1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(n), 64'(exp_edges));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {62'd0, ready1, ready0}, 64'd0);
        check_eq("rst_data_a", {32'd0, data_a1, data_a0}, 64'd0);
        check_eq("rst_data_b0", data_b0, 64'd0);
        check_eq("rst_data_b1", data_b1, 64'd0);
        check_eq("rst_flags", {58'd0, valid_a0, valid_a1, valid_b0, valid_b1, coll0, coll1}, 64'd0);

        // Clear: ready rises on the 64th edge; a write to A[0] late in the clear is dropped.
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd0; wdata_a = 16'hFFFF;
        en_b = 1'b1; we_b = 1'b0; addr_b = 4'd0;
        @(negedge clk);
        idle_inputs();
        check_eq("clear_va0", 64'(valid_a0), 64'd0);
        check_eq("clear_vb0", 64'(valid_b0), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("ready_early", {62'd0, ready1, ready0}, 64'd0);
        @(negedge clk);
        check_eq("ready_64", {62'd0, ready1, ready0}, 64'd3);

        for (int i = 0; i < 64; i++)
            do_op("clr_rd", 1, 0, 6'(i), 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'h0, 16'h0, 64'h0, 64'h0, 0);

        for (int i = 0; i < 4; i++)
            do_op("wr_a", 1, 1, 6'(8 + i), 16'(16'h1111 * (i + 1)), 0, 0, 4'h0, 4'h0, 64'h0,
                  16'h0, 16'(16'h1111 * (i + 1)), 64'h0, 64'h0, 0);
        do_op("rd_b2", 0, 0, 6'd0, 16'h0, 1, 0, 4'h0, 4'd2, 64'h0,
              16'h0, 16'h0, 64'h4444_3333_2222_1111, 64'h4444_3333_2222_1111, 0);

        do_op("wr_b_be", 0, 0, 6'd0, 16'h0, 1, 1, 4'b0101, 4'd2, 64'hAAAA_BBBB_CCCC_DDDD,
              16'h0, 16'h0, 64'h4444_3333_2222_1111, 64'h4444_BBBB_2222_DDDD, 0);
        do_op("rd_a8", 1, 0, 6'd8, 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'hDDDD, 16'hDDDD, 64'h0, 64'h0, 0);
        do_op("rd_a9", 1, 0, 6'd9, 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'h2222, 16'h2222, 64'h0, 64'h0, 0);
        do_op("rd_a10", 1, 0, 6'd10, 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'hBBBB, 16'hBBBB, 64'h0, 64'h0, 0);
        do_op("rd_a11", 1, 0, 6'd11, 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'h4444, 16'h4444, 64'h0, 64'h0, 0);

        do_op("rdw1", 1, 1, 6'd3, 16'h5A5A, 0, 0, 4'h0, 4'h0, 64'h0, 16'h0000, 16'h5A5A, 64'h0, 64'h0, 0);
        do_op("rdw2", 1, 1, 6'd3, 16'hA5A5, 0, 0, 4'h0, 4'h0, 64'h0, 16'h5A5A, 16'hA5A5, 64'h0, 64'h0, 0);
        do_op("rd_a3", 1, 0, 6'd3, 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'hA5A5, 16'hA5A5, 64'h0, 64'h0, 0);

        do_op("coll", 1, 1, 6'd9, 16'h1234, 1, 1, 4'b0010, 4'd2, 64'h0000_0000_BEEF_0000,
              16'h2222, 16'h0, 64'h4444_BBBB_2222_DDDD, 64'h4444_BBBB_BEEF_DDDD, 1);
        do_op("rd_a9_coll", 1, 0, 6'd9, 16'h0, 0, 0, 4'h0, 4'h0, 64'h0, 16'hBEEF, 16'hBEEF, 64'h0, 64'h0, 0);

        do_op("nocoll", 1, 1, 6'd10, 16'h7777, 1, 1, 4'b1000, 4'd2, 64'h9999_0000_0000_0000,
              16'hBBBB, 16'h7777, 64'h4444_BBBB_BEEF_DDDD, 64'h9999_BBBB_BEEF_DDDD, 0);
        do_op("rd_b2_end", 0, 0, 6'd0, 16'h0, 1, 0, 4'h0, 4'd2, 64'h0,
              16'h0, 16'h0, 64'h9999_7777_BEEF_DDDD, 64'h9999_7777_BEEF_DDDD, 0);
        check_eq("coll_cnt0", 64'(coll_cnt0), 64'd1);
        check_eq("coll_cnt1", 64'(coll_cnt1), 64'd1);

        // Reset lands before the edge that would have captured the B read.
        en_b = 1'b1; we_b = 1'b0; addr_b = 4'd2;
        #2 rst_n = 1'b0;
        @(negedge clk);
        idle_inputs();
        check_eq("mid_rst_vb", {62'd0, valid_b1, valid_b0}, 64'd0);
        check_eq("mid_rst_b0", data_b0, 64'd0);
        check_eq("mid_rst_b1", data_b1, 64'd0);
        check_eq("mid_rst_ready", {62'd0, ready1, ready0}, 64'd0);
        @(negedge clk);
        check_eq("mid_rst_vb_late", {62'd0, valid_b1, valid_b0}, 64'd0);
        rst_n = 1'b1;
        wait_ready("reclear_edges", 64);

        for (int k = 0; k < 16; k++)
            do_op("reclr_rd", 0, 0, 6'd0, 16'h0, 1, 0, 4'h0, 4'(k), 64'h0, 16'h0, 16'h0, 64'h0, 64'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
